// File: rtl/trap_pkg.sv
// Shared constants for the trap controller: status flag positions, cause indices, FSM states
// and the status-word to cause-vector mapping.
package trap_pkg;

  localparam int unsigned STATUS_W  = 20;
  localparam int unsigned NUM_CAUSE = 6;

  // Flag bit positions, matching the status register layout
  localparam int unsigned BIT_MEM_CORRUPT = 18;
  localparam int unsigned BIT_MEM_VIOLATE = 17;
  localparam int unsigned BIT_DIV_ZERO    = 14;
  localparam int unsigned BIT_OVERFLOW    = 11;
  localparam int unsigned BIT_UNDERFLOW   = 12;
  localparam int unsigned BIT_CARRY       = 13;

  // Cause indices, 0 = highest priority
  localparam logic [2:0] CAUSE_MEM_CORRUPT = 3'd0;
  localparam logic [2:0] CAUSE_MEM_VIOLATE = 3'd1;
  localparam logic [2:0] CAUSE_DIV_ZERO    = 3'd2;
  localparam logic [2:0] CAUSE_OVERFLOW    = 3'd3;
  localparam logic [2:0] CAUSE_UNDERFLOW   = 3'd4;
  localparam logic [2:0] CAUSE_CARRY       = 3'd5;

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StSave    = 3'd1,
    StVector  = 3'd2,
    StHandler = 3'd3,
    StClear   = 3'd4,
    StExit    = 3'd5
  } trap_state_e;

  function automatic logic [NUM_CAUSE-1:0] flags(input logic [STATUS_W-1:0] status);
    logic [NUM_CAUSE-1:0] f;
    f                    = '0;
    f[CAUSE_MEM_CORRUPT] = status[BIT_MEM_CORRUPT];
    f[CAUSE_MEM_VIOLATE] = status[BIT_MEM_VIOLATE];
    f[CAUSE_DIV_ZERO]    = status[BIT_DIV_ZERO];
    f[CAUSE_OVERFLOW]    = status[BIT_OVERFLOW];
    f[CAUSE_UNDERFLOW]   = status[BIT_UNDERFLOW];
    f[CAUSE_CARRY]       = status[BIT_CARRY];
    return f;
  endfunction

endpackage

// File: rtl/trap_prio_enc.sv
// Lowest-index-first priority encoder over the pending cause vector.
module trap_prio_enc #(
  parameter int unsigned N = 6
) (
  input  logic [N-1:0] i_req,
  output logic [2:0]   o_idx,
  output logic         o_any
);

  always_comb begin
    o_idx = '0;
    o_any = |i_req;
    // Scan downward so the lowest set index is the last one written
    for (int i = int'(N) - 1; i >= 0; i--) begin
      if (i_req[i]) o_idx = 3'(i);
    end
  end

endmodule

// File: rtl/trap_controller.sv
// Trap controller: latches enabled fault flags as pending causes and sequences trap
// entry, vectoring, handler XOR-clear and exit against the status register.
module trap_controller
  import trap_pkg::*;
#(
  parameter int unsigned        DATA_W   = 20,
  parameter int unsigned        NCAUSE   = 6,
  parameter logic [DATA_W-1:0]  VEC_BASE = 20'h00F00,
  parameter logic [NCAUSE-1:0]  MASK_RST = 6'b111111
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] i_status_in,
  input  logic              i_status_valid,
  input  logic              i_mask_wr,
  input  logic [NCAUSE-1:0] i_mask_data,
  input  logic              i_handler_ack,
  input  logic              i_clear_xor,
  input  logic              i_trap_return,
  output logic              o_trap,
  output logic              o_reg_to_instruction,
  output logic              o_xorData,
  output logic              o_vector_valid,
  output logic [DATA_W-1:0] o_vector_addr,
  output logic [2:0]        o_cause,
  output logic [NCAUSE-1:0] o_pending,
  output logic [DATA_W-1:0] o_saved_status,
  output logic              o_busy
);

  trap_state_e       r_state, w_state_d;
  logic [NCAUSE-1:0] r_mask;
  logic [NCAUSE-1:0] w_flags, w_new, w_svc_clr, w_pending_d;
  logic [2:0]        w_prio_idx, w_cause_d;
  logic              w_prio_any;
  logic              w_trap_d, w_rti_d, w_xor_d, w_vvalid_d, w_busy_d;
  logic [DATA_W-1:0] w_vaddr_d;

  assign w_flags = flags(i_status_in);
  assign w_new   = i_status_valid ? (w_flags & r_mask) : '0;

  trap_prio_enc #(
    .N (NCAUSE)
  ) u_prio (
    .i_req (o_pending),
    .o_idx (w_prio_idx),
    .o_any (w_prio_any)
  );

  always_comb begin
    w_svc_clr = '0;
    if (r_state == StSave && w_prio_any) w_svc_clr = NCAUSE'(1) << w_prio_idx;
    w_pending_d = (o_pending | w_new) & ~w_svc_clr;
    // A mask write also drops pending causes the new mask disables
    if (i_mask_wr) w_pending_d = w_pending_d & i_mask_data;
  end

  assign w_cause_d = (r_state == StSave) ? w_prio_idx : o_cause;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= StIdle;
    else       r_state <= w_state_d;
  end

  // Next-state logic
  always_comb begin
    w_state_d = r_state;
    unique case (r_state)
      StIdle:    if (|w_pending_d) w_state_d = StSave;
      StSave:    w_state_d = StVector;
      StVector:  if (i_handler_ack) w_state_d = StHandler;
      StHandler: begin
        if (i_trap_return)    w_state_d = StExit;
        else if (i_clear_xor) w_state_d = StClear;
      end
      StClear:   w_state_d = StHandler;
      StExit:    w_state_d = StIdle;
      default:   w_state_d = StIdle;
    endcase
  end

  // Output decode from the next state so registered outputs line up with the state
  always_comb begin
    w_trap_d   = (w_state_d == StSave) || (w_state_d == StVector) ||
                 (w_state_d == StHandler) || (w_state_d == StClear);
    w_rti_d    = (w_state_d == StSave);
    w_xor_d    = (w_state_d == StClear);
    w_vvalid_d = (w_state_d == StVector);
    w_busy_d   = (w_state_d != StIdle);
    w_vaddr_d  = w_vvalid_d ? (VEC_BASE + (DATA_W'(w_cause_d) << 2)) : '0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_mask               <= MASK_RST;
      o_pending            <= '0;
      o_cause              <= '0;
      o_saved_status       <= '0;
      o_trap               <= 1'b0;
      o_reg_to_instruction <= 1'b0;
      o_xorData            <= 1'b0;
      o_vector_valid       <= 1'b0;
      o_vector_addr        <= '0;
      o_busy               <= 1'b0;
    end else begin
      if (i_mask_wr) r_mask <= i_mask_data;
      o_pending <= w_pending_d;
      o_cause   <= w_cause_d;
      if (r_state == StSave) o_saved_status <= i_status_in;
      o_trap               <= w_trap_d;
      o_reg_to_instruction <= w_rti_d;
      o_xorData            <= w_xor_d;
      o_vector_valid       <= w_vvalid_d;
      o_vector_addr        <= w_vaddr_d;
      o_busy               <= w_busy_d;
    end
  end

endmodule

// File: tb/tb_trap_controller.sv
// Self-checking bench for trap_controller: table-driven single-trap vectors plus
// hand-written sequences for chained traps, held vectors, XOR-clear and mid-trap reset.
module tb_trap_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic [19:0] status_in;
  logic        status_valid, mask_wr, handler_ack, clear_xor, trap_return;
  logic [5:0]  mask_data;
  logic        trap, rti, xor_data, vector_valid, busy;
  logic [19:0] vector_addr, saved_status;
  logic [2:0]  cause;
  logic [5:0]  pending;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  trap_controller dut (
    .clk                  (clk),
    .reset                (reset),
    .i_status_in          (status_in),
    .i_status_valid       (status_valid),
    .i_mask_wr            (mask_wr),
    .i_mask_data          (mask_data),
    .i_handler_ack        (handler_ack),
    .i_clear_xor          (clear_xor),
    .i_trap_return        (trap_return),
    .o_trap               (trap),
    .o_reg_to_instruction (rti),
    .o_xorData            (xor_data),
    .o_vector_valid       (vector_valid),
    .o_vector_addr        (vector_addr),
    .o_cause              (cause),
    .o_pending            (pending),
    .o_saved_status       (saved_status),
    .o_busy               (busy)
  );

  typedef struct {
    logic [19:0] status;
    logic [5:0]  mask;
    logic        exp_trap;
    logic [2:0]  exp_cause;
    logic [19:0] exp_addr;
    logic [5:0]  exp_pend;
  } vec_t;

  vec_t vecs[11];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_mask(input logic [5:0] m);
    mask_wr   = 1'b1;
    mask_data = m;
    step();
    mask_wr   = 1'b0;
  endtask

  task automatic drain();
    bit done = 0;
    handler_ack = 1'b1;
    trap_return = 1'b1;
    for (int i = 0; i < 60 && !done; i++) begin
      step();
      if (!busy && pending == 6'd0) done = 1;
    end
    handler_ack = 1'b0;
    trap_return = 1'b0;
    chk("drain_idle", {31'd0, done}, 32'd1);
  endtask

  task automatic wait_vector(input string name);
    bit seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      step();
      if (vector_valid) seen = 1;
    end
    chk(name, {31'd0, seen}, 32'd1);
  endtask

  initial begin
    reset = 1'b1;
    status_in = '0; status_valid = 0; mask_wr = 0; mask_data = '0;
    handler_ack = 0; clear_xor = 0; trap_return = 0;

    vecs[0]  = '{20'h40000, 6'b111111, 1'b1, 3'd0, 20'h00F00, 6'b000000};
    vecs[1]  = '{20'h20000, 6'b111111, 1'b1, 3'd1, 20'h00F04, 6'b000000};
    vecs[2]  = '{20'h04000, 6'b111111, 1'b1, 3'd2, 20'h00F08, 6'b000000};
    vecs[3]  = '{20'h00800, 6'b111111, 1'b1, 3'd3, 20'h00F0C, 6'b000000};
    vecs[4]  = '{20'h01000, 6'b111111, 1'b1, 3'd4, 20'h00F10, 6'b000000};
    vecs[5]  = '{20'h02000, 6'b111111, 1'b1, 3'd5, 20'h00F14, 6'b000000};
    vecs[6]  = '{20'h20800, 6'b111111, 1'b1, 3'd1, 20'h00F04, 6'b001000};
    vecs[7]  = '{20'h03800, 6'b111111, 1'b1, 3'd3, 20'h00F0C, 6'b110000};
    vecs[8]  = '{20'h00800, 6'b110111, 1'b0, 3'd0, 20'h00000, 6'b000000};
    vecs[9]  = '{20'h42000, 6'b111110, 1'b1, 3'd5, 20'h00F14, 6'b000000};
    vecs[10] = '{20'h00001, 6'b111111, 1'b0, 3'd0, 20'h00000, 6'b000000};

    step(); step();
    chk("rst_trap", {31'd0, trap}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_vaddr", {12'd0, vector_addr}, 32'd0);
    reset = 1'b0;
    step();
    chk("idle_busy", {31'd0, busy}, 32'd0);
    chk("idle_pending", {26'd0, pending}, 32'd0);

    // Test 1 with saved_status capture
    status_in = 20'h04000; status_valid = 1'b1;
    step();
    status_valid = 1'b0;
    chk("t1_save_rti", {31'd0, rti}, 32'd1);
    chk("t1_save_trap", {31'd0, trap}, 32'd1);
    chk("t1_save_vvalid", {31'd0, vector_valid}, 32'd0);
    step();
    status_in = '0;
    chk("t1_vec_valid", {31'd0, vector_valid}, 32'd1);
    chk("t1_vec_addr", {12'd0, vector_addr}, 32'h00F08);
    chk("t1_cause", {29'd0, cause}, 32'd2);
    chk("t1_rti_off", {31'd0, rti}, 32'd0);
    chk("t1_saved", {12'd0, saved_status}, 32'h04000);
    drain();

    // Table-driven single-flag and priority vectors
    foreach (vecs[k]) begin
      write_mask(vecs[k].mask);
      status_in = vecs[k].status; status_valid = 1'b1;
      step();
      status_valid = 1'b0;
      status_in = '0;
      chk($sformatf("v%0d_rti", k), {31'd0, rti}, {31'd0, vecs[k].exp_trap});
      step();
      chk($sformatf("v%0d_vvalid", k), {31'd0, vector_valid}, {31'd0, vecs[k].exp_trap});
      chk($sformatf("v%0d_addr", k), {12'd0, vector_addr}, {12'd0, vecs[k].exp_addr});
      if (vecs[k].exp_trap) chk($sformatf("v%0d_cause", k), {29'd0, cause},
                                {29'd0, vecs[k].exp_cause});
      chk($sformatf("v%0d_pend", k), {26'd0, pending}, {26'd0, vecs[k].exp_pend});
      chk($sformatf("v%0d_busy", k), {31'd0, busy}, {31'd0, vecs[k].exp_trap});
      drain();
    end
    write_mask(6'b111111);

    // Test 2: chained trap from leftover pending
    status_in = 20'h20800; status_valid = 1'b1;
    step();
    status_valid = 1'b0; status_in = '0;
    step();
    chk("t2_addr1", {12'd0, vector_addr}, 32'h00F04);
    chk("t2_pend1", {26'd0, pending}, 32'b001000);
    handler_ack = 1'b1; step(); handler_ack = 1'b0;
    trap_return = 1'b1; step(); trap_return = 1'b0;
    chk("t2_exit_trap", {31'd0, trap}, 32'd0);
    chk("t2_exit_busy", {31'd0, busy}, 32'd1);
    wait_vector("t2_second_vector");
    chk("t2_addr2", {12'd0, vector_addr}, 32'h00F0C);
    chk("t2_cause2", {29'd0, cause}, 32'd3);
    chk("t2_pend2", {26'd0, pending}, 32'd0);

    // Test 4: vector held while ack low; flags during the trap only accumulate
    status_in = 20'h40000; status_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      status_valid = 1'b0;
      chk($sformatf("t4_hold%0d_valid", i), {31'd0, vector_valid}, 32'd1);
      chk($sformatf("t4_hold%0d_addr", i), {12'd0, vector_addr}, 32'h00F0C);
    end
    chk("t4_pend_accum", {26'd0, pending}, 32'b000001);
    handler_ack = 1'b1; step(); handler_ack = 1'b0;
    chk("t4_handler_vvalid", {31'd0, vector_valid}, 32'd0);
    chk("t4_handler_vaddr", {12'd0, vector_addr}, 32'd0);
    chk("t4_handler_trap", {31'd0, trap}, 32'd1);

    // Test 5: XOR-clear, then clear+return together
    clear_xor = 1'b1; step(); clear_xor = 1'b0;
    chk("t5_xor_on", {31'd0, xor_data}, 32'd1);
    chk("t5_xor_trap", {31'd0, trap}, 32'd1);
    step();
    chk("t5_xor_off", {31'd0, xor_data}, 32'd0);
    chk("t5_back_trap", {31'd0, trap}, 32'd1);
    clear_xor = 1'b1; trap_return = 1'b1; step();
    clear_xor = 1'b0; trap_return = 1'b0;
    chk("t5_both_xor", {31'd0, xor_data}, 32'd0);
    chk("t5_both_trap", {31'd0, trap}, 32'd0);
    chk("t5_both_busy", {31'd0, busy}, 32'd1);
    wait_vector("t5_retrigger");
    chk("t5_retrig_addr", {12'd0, vector_addr}, 32'h00F00);

    // Test 6: asynchronous reset mid-VECTOR restores the reset mask
    write_mask(6'b000000);
    #2 reset = 1'b1;
    #1;
    chk("t6_rst_vvalid", {31'd0, vector_valid}, 32'd0);
    chk("t6_rst_trap", {31'd0, trap}, 32'd0);
    chk("t6_rst_busy", {31'd0, busy}, 32'd0);
    chk("t6_rst_vaddr", {12'd0, vector_addr}, 32'd0);
    chk("t6_rst_cause", {29'd0, cause}, 32'd0);
    step();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("t6_quiet%0d", i), {31'd0, vector_valid | busy}, 32'd0);
    end
    status_in = 20'h00800; status_valid = 1'b1;
    step();
    status_valid = 1'b0; status_in = '0;
    chk("t6_mask_rst_trap", {31'd0, rti}, 32'd1);
    step();
    chk("t6_mask_rst_addr", {12'd0, vector_addr}, 32'h00F0C);
    drain();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
